// File: rtl/vec_alu_arbiter_pkg.sv
// Shared types and constants for the VecALU arbiter: lane geometry, vector type,
// arbiter states and the opcode names used by requesters.
package vec_pkg;

  localparam int N   = 8;
  localparam int V   = 16;
  localparam int OPW = 3;

  typedef logic [V-1:0][N-1:0] vec_t;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;

  localparam logic [OPW-1:0] OP_ADD    = 3'd0;
  localparam logic [OPW-1:0] OP_SUB    = 3'd1;
  localparam logic [OPW-1:0] OP_AND    = 3'd2;
  localparam logic [OPW-1:0] OP_OR     = 3'd3;
  localparam logic [OPW-1:0] OP_XOR    = 3'd4;
  localparam logic [OPW-1:0] OP_DUPLEX = 3'b111;

  // Ports allowed to win arbitration in a given state, bit i = port i.
  function automatic logic [1:0] elig_mask(arb_state_t s);
    case (s)
      LOCK0:   return 2'b01;
      LOCK1:   return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

endpackage

// File: rtl/vec_alu_arbiter_if.sv
// Bundle of both requester ports, the ALU drive/return and the result port.
// slave = arbiter side, master = requesters/ALU/consumer side.
interface vec_alu_arbiter_if;
  import vec_pkg::*;

  logic           req0_valid;
  logic           req0_lock;
  logic [OPW-1:0] req0_op;
  vec_t           req0_a;
  vec_t           req0_b;
  logic           req0_ready;

  logic           req1_valid;
  logic           req1_lock;
  logic [OPW-1:0] req1_op;
  vec_t           req1_a;
  vec_t           req1_b;
  logic           req1_ready;

  logic [OPW-1:0] alu_op;
  vec_t           alu_a;
  vec_t           alu_b;
  vec_t           alu_result;

  logic           res_valid;
  logic           res_id;
  vec_t           res_data;
  logic           res_ready;

  modport slave (
    input  req0_valid, req0_lock, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_lock, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_op, alu_a, alu_b,
    input  alu_result,
    output res_valid, res_id, res_data,
    input  res_ready
  );

  modport master (
    output req0_valid, req0_lock, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_lock, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_op, alu_a, alu_b,
    output alu_result,
    input  res_valid, res_id, res_data,
    output res_ready
  );

endinterface

// File: rtl/vec_alu_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin grant: among eligible valid ports a lone
// requester wins, a tie goes to the port that did not win last.
module rr_arbiter2 (
  input  logic [1:0] valid_i,
  input  logic [1:0] elig_i,
  input  logic       last_grant_i,
  output logic       gnt_valid_o,
  output logic       gnt_id_o
);

  logic [1:0] cand;

  assign cand = valid_i & elig_i;

  always_comb begin
    gnt_valid_o = |cand;
    gnt_id_o    = 1'b0;
    if (cand == 2'b11) begin
      gnt_id_o = ~last_grant_i;
    end else if (cand == 2'b10) begin
      gnt_id_o = 1'b1;
    end
  end

endmodule

// File: rtl/vec_alu_arbiter.sv
// Shares one combinational VecALU between two requesters with round-robin
// arbitration, optional locked bursts and a single registered result stage.
//
// state | meaning
// ARB   | both ports eligible, round-robin on contention
// LOCK0 | burst in progress, only port 0 may be granted
// LOCK1 | burst in progress, only port 1 may be granted
module vec_alu_arbiter
  import vec_pkg::*;
(
  input logic              clk,
  input logic              rst_n,
  vec_alu_arbiter_if.slave bus
);

  arb_state_t state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       res_valid_q, res_valid_d;
  logic       res_id_q, res_id_d;
  vec_t       res_data_q, res_data_d;

  logic [1:0] req_valid;
  logic       gnt_valid;
  logic       gnt_id;
  logic       can_accept;
  logic       hs;
  logic       hs_lock;

  assign req_valid = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_rr (
    .valid_i      (req_valid),
    .elig_i       (elig_mask(state_q)),
    .last_grant_i (last_grant_q),
    .gnt_valid_o  (gnt_valid),
    .gnt_id_o     (gnt_id)
  );

  // Nothing is accepted while reset is asserted, so no op is lost across it.
  assign can_accept = rst_n & (~res_valid_q | bus.res_ready);
  assign hs         = can_accept & gnt_valid;

  assign bus.req0_ready = hs & ~gnt_id;
  assign bus.req1_ready = hs & gnt_id;

  // Port 0 fields are the idle default on the ALU inputs.
  assign bus.alu_op = (gnt_valid & gnt_id) ? bus.req1_op : bus.req0_op;
  assign bus.alu_a  = (gnt_valid & gnt_id) ? bus.req1_a  : bus.req0_a;
  assign bus.alu_b  = (gnt_valid & gnt_id) ? bus.req1_b  : bus.req0_b;

  assign hs_lock = gnt_id ? bus.req1_lock : bus.req0_lock;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    res_valid_d  = res_valid_q;
    res_id_d     = res_id_q;
    res_data_d   = res_data_q;
    if (hs) begin
      res_data_d   = bus.alu_result;
      res_id_d     = gnt_id;
      res_valid_d  = 1'b1;
      last_grant_d = gnt_id;
      case (state_q)
        ARB: begin
          if (hs_lock) state_d = gnt_id ? LOCK1 : LOCK0;
        end
        LOCK0, LOCK1: begin
          if (!hs_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      res_valid_q  <= 1'b0;
      res_id_q     <= 1'b0;
      res_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      res_valid_q  <= res_valid_d;
      res_id_q     <= res_id_d;
      res_data_q   <= res_data_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_id    = res_id_q;
  assign bus.res_data  = res_data_q;

endmodule

// File: tb/tb_vec_alu_arbiter.sv
// Directed bench for vec_alu_arbiter with a small lane-wise ALU model on the
// alu_* loop; inputs change 1ns after the rising edge, outputs are checked there.
module tb_vec_alu_arbiter;
  import vec_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  vec_alu_arbiter_if bus();

  vec_alu_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic vec_t fill(logic [7:0] x);
    vec_t r;
    for (int i = 0; i < V; i++) r[i] = x;
    return r;
  endfunction

  function automatic vec_t alu_model(logic [OPW-1:0] op, vec_t a, vec_t b);
    vec_t r;
    for (int i = 0; i < V; i++) begin
      case (op)
        OP_ADD:  r[i] = a[i] + b[i];
        OP_SUB:  r[i] = a[i] - b[i];
        OP_AND:  r[i] = a[i] & b[i];
        OP_OR:   r[i] = a[i] | b[i];
        OP_XOR:  r[i] = a[i] ^ b[i];
        default: r[i] = {a[i][3:0], b[i][3:0]};
      endcase
    end
    return r;
  endfunction

  assign bus.alu_result = alu_model(bus.alu_op, bus.alu_a, bus.alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.res_ready = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_lock = 1'b0; bus.req0_op = OP_ADD;
    bus.req0_a = fill(8'h05); bus.req0_b = fill(8'h03);
    bus.req1_valid = 1'b1; bus.req1_lock = 1'b0; bus.req1_op = OP_SUB;
    bus.req1_a = fill(8'h10); bus.req1_b = fill(8'h04);
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid); end
      n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
      n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready1: got %b want 0", bus.req1_ready); end
    end
    n_cmp++; if (bus.res_data !== fill(8'h00)) begin n_err++; $display("FAIL reset_res_data: got %h want 0", bus.res_data); end
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL first_grant_ready0: got %b want 1", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL first_grant_ready1: got %b want 0", bus.req1_ready); end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    n_cmp++; if (bus.res_id !== 1'b0) begin n_err++; $display("FAIL first_grant_res_id: got %b want 0", bus.res_id); end
    n_cmp++; if (bus.res_data !== fill(8'h08)) begin n_err++; $display("FAIL first_grant_data: got %h want 08s", bus.res_data); end
    tick();
  endtask

  task automatic test_idle_drive();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_op = OP_OR;  bus.req0_a = fill(8'h11);
    bus.req1_op = OP_XOR; bus.req1_a = fill(8'h22);
    #1;
    n_cmp++; if (bus.alu_a !== fill(8'h11)) begin n_err++; $display("FAIL idle_alu_a: got %h want 11s", bus.alu_a); end
    n_cmp++; if (bus.alu_op !== OP_OR) begin n_err++; $display("FAIL idle_alu_op: got %0d want %0d", bus.alu_op, OP_OR); end
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = fill(8'h05); bus.req0_b = fill(8'h03);
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL single0_ready: got %b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0;
    n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL single0_valid: got %b want 1", bus.res_valid); end
    n_cmp++; if (bus.res_id !== 1'b0) begin n_err++; $display("FAIL single0_id: got %b want 0", bus.res_id); end
    n_cmp++; if (bus.res_data !== fill(8'h08)) begin n_err++; $display("FAIL single0_data: got %h want 08s", bus.res_data); end
    tick();
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL single0_drain: got %b want 0", bus.res_valid); end
    bus.req1_valid = 1'b1; bus.req1_op = OP_AND; bus.req1_a = fill(8'hF0); bus.req1_b = fill(8'h3C);
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL single1_ready: got %b want 1", bus.req1_ready); end
    tick();
    bus.req1_valid = 1'b0;
    n_cmp++; if (bus.res_id !== 1'b1) begin n_err++; $display("FAIL single1_id: got %b want 1", bus.res_id); end
    n_cmp++; if (bus.res_data !== fill(8'h30)) begin n_err++; $display("FAIL single1_data: got %h want 30s", bus.res_data); end
    tick();
  endtask

  task automatic test_contention();
    logic exp;
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = fill(8'h05); bus.req0_b = fill(8'h03);
    bus.req1_valid = 1'b1; bus.req1_op = OP_SUB; bus.req1_a = fill(8'h10); bus.req1_b = fill(8'h04);
    for (int i = 0; i < 8; i++) begin
      exp = i[0];
      #1;
      n_cmp++; if (bus.req0_ready !== ~exp) begin n_err++; $display("FAIL contend_ready0[%0d]: got %b want %b", i, bus.req0_ready, ~exp); end
      n_cmp++; if (bus.req1_ready !== exp) begin n_err++; $display("FAIL contend_ready1[%0d]: got %b want %b", i, bus.req1_ready, exp); end
      tick();
      n_cmp++; if (bus.res_id !== exp) begin n_err++; $display("FAIL contend_id[%0d]: got %b want %b", i, bus.res_id, exp); end
      n_cmp++; if (bus.res_data !== (exp ? fill(8'h0C) : fill(8'h08))) begin n_err++; $display("FAIL contend_data[%0d]: got %h", i, bus.res_data); end
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_lock_burst();
    bus.req0_valid = 1'b1; bus.req0_lock = 1'b0; bus.req0_op = OP_ADD;
    bus.req0_a = fill(8'h05); bus.req0_b = fill(8'h03);
    bus.req1_valid = 1'b1; bus.req1_lock = 1'b1; bus.req1_op = OP_SUB;
    bus.req1_a = fill(8'h10); bus.req1_b = fill(8'h01);
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL lock_pre_ready0: got %b want 1", bus.req0_ready); end
    tick();
    for (int k = 1; k <= 4; k++) begin
      bus.req1_b = fill(8'(k));
      bus.req1_lock = (k < 4);
      #1;
      n_cmp++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL lock_ready1[%0d]: got %b want 1", k, bus.req1_ready); end
      n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL lock_ready0[%0d]: got %b want 0", k, bus.req0_ready); end
      tick();
      n_cmp++; if (bus.res_id !== 1'b1) begin n_err++; $display("FAIL lock_id[%0d]: got %b want 1", k, bus.res_id); end
      n_cmp++; if (bus.res_data !== fill(8'h10 - 8'(k))) begin n_err++; $display("FAIL lock_data[%0d]: got %h", k, bus.res_data); end
      if (k == 1) begin
        bus.req1_valid = 1'b0;
        #1;
        n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL lock_idle_ready0: got %b want 0", bus.req0_ready); end
        tick();
        bus.req1_valid = 1'b1;
      end
    end
    bus.req1_valid = 1'b0;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL unlock_ready0: got %b want 1", bus.req0_ready); end
    tick();
    bus.req0_valid = 1'b0;
    n_cmp++; if (bus.res_id !== 1'b0) begin n_err++; $display("FAIL unlock_id: got %b want 0", bus.res_id); end
    tick();
  endtask

  task automatic test_backpressure();
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = fill(8'h05); bus.req0_b = fill(8'h03);
    tick();
    bus.req0_valid = 1'b0;
    bus.res_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_lock = 1'b0; bus.req1_op = OP_XOR;
    bus.req1_a = fill(8'hF0); bus.req1_b = fill(8'h0F);
    for (int c = 0; c < 4; c++) begin
      #1;
      n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready1[%0d]: got %b want 0", c, bus.req1_ready); end
      n_cmp++; if (bus.req0_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready0[%0d]: got %b want 0", c, bus.req0_ready); end
      tick();
      n_cmp++; if (bus.res_id !== 1'b0) begin n_err++; $display("FAIL bp_id[%0d]: got %b want 0", c, bus.res_id); end
      n_cmp++; if (bus.res_data !== fill(8'h08)) begin n_err++; $display("FAIL bp_data[%0d]: got %h want 08s", c, bus.res_data); end
    end
    bus.res_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req1_ready !== 1'b1) begin n_err++; $display("FAIL bp_release_ready1: got %b want 1", bus.req1_ready); end
    tick();
    bus.req1_valid = 1'b0;
    n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL bp_release_valid: got %b want 1", bus.res_valid); end
    n_cmp++; if (bus.res_id !== 1'b1) begin n_err++; $display("FAIL bp_release_id: got %b want 1", bus.res_id); end
    n_cmp++; if (bus.res_data !== fill(8'hFF)) begin n_err++; $display("FAIL bp_release_data: got %h want FFs", bus.res_data); end
    tick();
  endtask

  task automatic test_duplex();
    bus.req1_valid = 1'b1; bus.req1_lock = 1'b0; bus.req1_op = OP_DUPLEX;
    bus.req1_a = fill(8'h3C); bus.req1_b = fill(8'h5A);
    #1;
    n_cmp++; if (bus.alu_op !== 3'b111) begin n_err++; $display("FAIL duplex_alu_op: got %0d want 7", bus.alu_op); end
    n_cmp++; if (bus.alu_b !== fill(8'h5A)) begin n_err++; $display("FAIL duplex_alu_b: got %h want 5As", bus.alu_b); end
    tick();
    bus.req1_valid = 1'b0;
    n_cmp++; if (bus.res_data !== fill(8'hCA)) begin n_err++; $display("FAIL duplex_data: got %h want CAs", bus.res_data); end
    tick();
  endtask

  task automatic test_mid_reset();
    bus.res_ready = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_lock = 1'b1; bus.req1_op = OP_SUB;
    bus.req1_a = fill(8'h10); bus.req1_b = fill(8'h01);
    tick();
    n_cmp++; if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL midrst_pre_valid: got %b want 1", bus.res_valid); end
    bus.req1_lock = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = OP_ADD; bus.req0_a = fill(8'h05); bus.req0_b = fill(8'h03);
    rst_n = 1'b0;
    tick();
    n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus.res_valid); end
    n_cmp++; if (bus.res_id !== 1'b0) begin n_err++; $display("FAIL midrst_id: got %b want 0", bus.res_id); end
    rst_n = 1'b1;
    bus.res_ready = 1'b1;
    #1;
    n_cmp++; if (bus.req0_ready !== 1'b1) begin n_err++; $display("FAIL midrst_ready0: got %b want 1", bus.req0_ready); end
    n_cmp++; if (bus.req1_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready1: got %b want 0", bus.req1_ready); end
    tick();
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    n_cmp++; if (bus.res_id !== 1'b0) begin n_err++; $display("FAIL midrst_next_id: got %b want 0", bus.res_id); end
    n_cmp++; if (bus.res_data !== fill(8'h08)) begin n_err++; $display("FAIL midrst_next_data: got %h want 08s", bus.res_data); end
    tick();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_idle_drive();
    test_single();
    test_contention();
    test_lock_burst();
    test_backpressure();
    test_duplex();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, compared %0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule
